// File: rtl/stack_pkg.sv
// Shared definitions for the data-stack datapath: default widths, spill/fill
// controller state encoding, and DSOP bit positions used by control and
// data_stack.
package stack_pkg;

    localparam int unsigned WIDTH  = 16;   // data word width
    localparam int unsigned DEPTH  = 128;  // register stack entries
    localparam int unsigned ADDR_W = 10;   // overflow memory address width

    // DSOP bit positions
    localparam int unsigned DSOP_POP   = 3;
    localparam int unsigned DSOP_PUSH  = 2;
    localparam int unsigned DSOP_WRITE = 1;
    localparam int unsigned DSOP_READ  = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SPILL     = 2'd1,
        FILL_RD   = 2'd2,
        FILL_LOAD = 2'd3
    } spill_state_t;

endpackage

// File: rtl/stack_spill_ctrl_if.sv
// Bundle between control / data_stack / overflow memory and stack_spill_ctrl.
//   master : control-side view (drives occupancy and push/pop, sees status)
//   slave  : stack_spill_ctrl view
// Optional SPILL_STATS_EN adds spill_count / fill_count.
interface stack_spill_ctrl_if
    import stack_pkg::*;
#(
    parameter int unsigned ADDR_W = stack_pkg::ADDR_W
);
    logic [7:0]        ds_size;
    logic              ds_push;
    logic              ds_pop;
    logic              stall;
    logic              spill_shift;
    logic              fill_shift;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [ADDR_W:0]   mem_count;
    logic              mem_empty;
    logic              mem_full;
    logic              overflow_err;
    logic              underflow_err;
    logic              protocol_err;
`ifdef SPILL_STATS_EN
    logic [15:0]       spill_count;
    logic [15:0]       fill_count;
`endif

    modport master (
        output ds_size, ds_push, ds_pop,
        input  stall, spill_shift, fill_shift, mem_addr, mem_we, mem_count,
               mem_empty, mem_full, overflow_err, underflow_err, protocol_err
`ifdef SPILL_STATS_EN
        , input spill_count, fill_count
`endif
    );

    modport slave (
        input  ds_size, ds_push, ds_pop,
        output stall, spill_shift, fill_shift, mem_addr, mem_we, mem_count,
               mem_empty, mem_full, overflow_err, underflow_err, protocol_err
`ifdef SPILL_STATS_EN
        , output spill_count, fill_count
`endif
    );

endinterface

// File: rtl/stack_spill_ctrl.sv
// Spill/fill sequencer between the register data stack and its single-port
// overflow memory. Spills the bottom entry when occupancy reaches HIGH_WATER,
// restores one when it drops to LOW_WATER, and stalls control meanwhile.
// Ports:
//   clk, async_reset (async, active high)
//   bus (stack_spill_ctrl_if.slave): ds_size/ds_push/ds_pop in;
//     stall, spill_shift, fill_shift, mem_addr, mem_we, mem_count,
//     mem_empty, mem_full, sticky overflow/underflow/protocol errors out.
// Optional macro SPILL_STATS_EN: saturating spill_count / fill_count outputs.
module stack_spill_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned DEPTH      = stack_pkg::DEPTH,
    parameter int unsigned ADDR_W     = stack_pkg::ADDR_W,
    parameter int unsigned HIGH_WATER = 120,
    parameter int unsigned LOW_WATER  = 8
) (
    input  logic               clk,
    input  logic               async_reset,
    stack_spill_ctrl_if.slave  bus
);

    localparam logic [7:0]      L_DEPTH = 8'(DEPTH);
    localparam logic [7:0]      L_HIGH  = 8'(HIGH_WATER);
    localparam logic [7:0]      L_LOW   = 8'(LOW_WATER);
    localparam logic [ADDR_W:0] L_CAP   = {1'b1, {ADDR_W{1'b0}}};

    spill_state_t    r_state, w_next;
    logic [ADDR_W:0] r_mem_count;
    logic [ADDR_W:0] w_cnt_dec;
    logic            w_mem_full, w_mem_empty;
    logic            w_spill_cond, w_fill_cond;
    logic            w_stall, w_spill_shift, w_fill_shift, w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic            r_ovf_err, r_unf_err, r_prot_err;

    assign w_mem_full   = (r_mem_count == L_CAP);
    assign w_mem_empty  = (r_mem_count == '0);
    assign w_cnt_dec    = r_mem_count - (ADDR_W+1)'(1);
    assign w_spill_cond = (bus.ds_size >= L_HIGH) && !w_mem_full;
    assign w_fill_cond  = (bus.ds_size <= L_LOW)  && !w_mem_empty;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) r_state <= IDLE;
        else             r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_stall       = 1'b1;
        w_spill_shift = 1'b0;
        w_fill_shift  = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_addr    = r_mem_count[ADDR_W-1:0];
        case (r_state)
            IDLE: begin
                // Stall is raised in the decision cycle itself so control
                // never issues an op alongside the transfer that follows.
                w_stall = w_spill_cond || w_fill_cond;
                if (w_spill_cond)     w_next = SPILL;
                else if (w_fill_cond) w_next = FILL_RD;
            end
            SPILL: begin
                w_mem_we      = 1'b1;
                w_spill_shift = 1'b1;
                w_next        = IDLE;
            end
            FILL_RD: begin
                w_mem_addr = w_cnt_dec[ADDR_W-1:0];
                w_next     = FILL_LOAD;
            end
            FILL_LOAD: begin
                w_mem_addr   = w_cnt_dec[ADDR_W-1:0];
                w_fill_shift = 1'b1;
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset)               r_mem_count <= '0;
        else if (r_state == SPILL)     r_mem_count <= r_mem_count + (ADDR_W+1)'(1);
        else if (r_state == FILL_LOAD) r_mem_count <= w_cnt_dec;
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_ovf_err  <= 1'b0;
            r_unf_err  <= 1'b0;
            r_prot_err <= 1'b0;
        end else begin
            if (bus.ds_push && (bus.ds_size == L_DEPTH) && w_mem_full) r_ovf_err <= 1'b1;
            if (bus.ds_pop && (bus.ds_size == '0) && w_mem_empty)      r_unf_err <= 1'b1;
            if ((bus.ds_push || bus.ds_pop) && w_stall)                r_prot_err <= 1'b1;
        end
    end

    assign bus.stall         = w_stall;
    assign bus.spill_shift   = w_spill_shift;
    assign bus.fill_shift    = w_fill_shift;
    assign bus.mem_addr      = w_mem_addr;
    assign bus.mem_we        = w_mem_we;
    assign bus.mem_count     = r_mem_count;
    assign bus.mem_empty     = w_mem_empty;
    assign bus.mem_full      = w_mem_full;
    assign bus.overflow_err  = r_ovf_err;
    assign bus.underflow_err = r_unf_err;
    assign bus.protocol_err  = r_prot_err;

`ifdef SPILL_STATS_EN
    logic [15:0] r_spill_count, r_fill_count;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_spill_count <= '0;
            r_fill_count  <= '0;
        end else begin
            if (r_state == SPILL && r_spill_count != '1)
                r_spill_count <= r_spill_count + 16'd1;
            if (r_state == FILL_LOAD && r_fill_count != '1)
                r_fill_count <= r_fill_count + 16'd1;
        end
    end

    assign bus.spill_count = r_spill_count;
    assign bus.fill_count  = r_fill_count;
`endif

endmodule

// File: tb/tb_stack_spill_ctrl.sv
// Randomised directed bench for stack_spill_ctrl with a transfer-level
// reference model (memory occupancy + remaining busy cycles of the current
// transfer). Honours SPILL_STATS_EN when defined.
module tb_stack_spill_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stack_spill_ctrl_if #(.ADDR_W(10)) bus ();

    stack_spill_ctrl #(
        .DEPTH(128), .ADDR_W(10), .HIGH_WATER(120), .LOW_WATER(8)
    ) dut (
        .clk(clk), .async_reset(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_cnt;        // entries held in memory
    int m_left;       // cycles remaining in current transfer (0 = none)
    bit m_is_fill;
    bit m_ovf, m_unf, m_prot;
    int m_spills, m_fills;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_left = 0; m_is_fill = 0;
        m_ovf = 0; m_unf = 0; m_prot = 0;
        m_spills = 0; m_fills = 0;
    endtask

    function automatic bit spill_wanted(int ds);
        return ds >= 120 && m_cnt < 1024;
    endfunction

    function automatic bit fill_wanted(int ds);
        return ds <= 8 && m_cnt > 0;
    endfunction

    function automatic bit exp_stall(int ds);
        return m_left > 0 || spill_wanted(ds) || fill_wanted(ds);
    endfunction

    task automatic check_all(input string tag);
        int  ds;
        bit  spilling, loading;
        int  addr;
        ds       = int'(bus.ds_size);
        spilling = (m_left > 0) && !m_is_fill;
        loading  = (m_left == 1) && m_is_fill;
        addr     = m_is_fill && m_left > 0 ? (m_cnt - 1) % 1024 : m_cnt % 1024;
        chk({tag, ".stall"},  32'(bus.stall), 32'(exp_stall(ds)));
        chk({tag, ".spill"},  32'(bus.spill_shift), 32'(spilling));
        chk({tag, ".fill"},   32'(bus.fill_shift), 32'(loading));
        chk({tag, ".we"},     32'(bus.mem_we), 32'(spilling));
        chk({tag, ".addr"},   32'(bus.mem_addr), 32'(addr));
        chk({tag, ".count"},  32'(bus.mem_count), 32'(m_cnt));
        chk({tag, ".empty"},  32'(bus.mem_empty), 32'(m_cnt == 0));
        chk({tag, ".full"},   32'(bus.mem_full), 32'(m_cnt == 1024));
        chk({tag, ".ovf"},    32'(bus.overflow_err), 32'(m_ovf));
        chk({tag, ".unf"},    32'(bus.underflow_err), 32'(m_unf));
        chk({tag, ".prot"},   32'(bus.protocol_err), 32'(m_prot));
`ifdef SPILL_STATS_EN
        chk({tag, ".nspill"}, 32'(bus.spill_count), 32'(m_spills));
        chk({tag, ".nfill"},  32'(bus.fill_count), 32'(m_fills));
`endif
    endtask

    // Advance the model across one clock edge using the inputs of that cycle.
    task automatic model_edge(input int ds, input bit push, input bit pop);
        bit st;
        st = exp_stall(ds);
        if (push && ds == 128 && m_cnt == 1024) m_ovf = 1;
        if (pop && ds == 0 && m_cnt == 0)       m_unf = 1;
        if ((push || pop) && st)                m_prot = 1;
        if (m_left > 0) begin
            if (!m_is_fill) begin
                m_cnt++;
                if (m_spills < 65535) m_spills++;
            end else if (m_left == 1) begin
                m_cnt--;
                if (m_fills < 65535) m_fills++;
            end
            m_left--;
        end else if (spill_wanted(ds)) begin
            m_left = 1; m_is_fill = 0;
        end else if (fill_wanted(ds)) begin
            m_left = 2; m_is_fill = 1;
        end
    endtask

    // Called shortly after a negedge: drive, check, cross the posedge.
    task automatic step(input string tag, input int ds, input bit push, input bit pop);
        bus.ds_size = 8'(ds);
        bus.ds_push = push;
        bus.ds_pop  = pop;
        #1;
        check_all(tag);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(ds, push, pop);
        @(negedge clk);
    endtask

    initial begin
        bus.ds_size = '0;
        bus.ds_push = 1'b0;
        bus.ds_pop  = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Quiet zone: occupancy between watermarks, random ops never stall
        for (int i = 0; i < 20; i++)
            step("quiet", int'($urandom_range(9, 119)), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 4; i++) step("empty_idle", 0, 0, 0);

        // Spill three entries from the high-water boundary upwards
        step("spill_first", 120, 0, 0);
        for (int i = 0; i < 5; i++)
            step("spill", int'($urandom_range(120, 127)), 0, 0);
        chk("three_spilled", 32'(bus.mem_count), 32'd3);

        // Fill with ds at LOW_WATER: decision, FILL_RD (addr 2), FILL_LOAD
        step("fill_dec", 8, 0, 0);
        step("fill_rd", 8, 0, 0);
        step("fill_load", 8, 0, 0);
        chk("two_left", 32'(bus.mem_count), 32'd2);

        // Drain to empty, last fill reads address 0
        for (int i = 0; i < 8; i++)
            step("drain", int'($urandom_range(1, 8)), 0, 0);
        chk("drained", 32'(bus.mem_empty), 32'd1);

        // Pop at empty stack with empty memory
        step("underflow", 0, 0, 1);
        step("underflow_hold", 0, 0, 0);

        // Push while stalled in SPILL: protocol error, one spill only
        step("prot_dec", 121, 0, 0);
        step("prot_spill", 121, 1, 0);
        chk("prot_one_spill", 32'(bus.mem_count), 32'd1);
        step("prot_after", 100, 0, 0);

        // Random mixed traffic
        for (int i = 0; i < 60; i++)
            step("mixed", int'($urandom_range(0, 128)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0));

        // Fill memory to capacity (bounded)
        for (int i = 0; i < 2200 && m_cnt < 1024; i++) step("to_full", 128, 0, 0);
        chk("reached_full", 32'(bus.mem_count), 32'd1024);
        for (int i = 0; i < 3; i++) step("full_hold", int'($urandom_range(120, 128)), 0, 0);
        step("overflow", 128, 1, 0);
        step("overflow_sticky", 128, 0, 0);

        // Drain a few, then reset during FILL_RD
        for (int i = 0; i < 6; i++) step("pre_rst", 8, 0, 0);
        while (!(m_left == 0 && fill_wanted(8))) step("align", 8, 0, 0);
        step("rst_dec", 8, 0, 0);
        bus.ds_size = 8'd8;
        #1;
        chk("in_fill_rd", 32'(m_left), 32'd2);
        check_all("fill_rd_before_rst");
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        step("rst_held", 8, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("post_rst", 8, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
